// File: rtl/enc_gray_arb.sv
// Two-requester round-robin binary-to-Gray converter with a single
// registered output slot and a count of consumed results.
module enc_gray_arb #(
    parameter int WIDTH = 10,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_bin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_bin,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gray,
    output logic             out_id,
    output logic [CNTW-1:0]  conv_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] acc_bin;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             slot_free;
    logic             grant0, grant1;
    logic             accept;
    logic             fire;

    // last_q holds the id granted at the previous acceptance; the other wins ties
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        unique case (1'b1)
            (req0_valid && req1_valid): begin
                grant0 = last_q;
                grant1 = !last_q;
            end
            (req0_valid && !req1_valid): grant0 = 1'b1;
            (!req0_valid && req1_valid): grant1 = 1'b1;
            default: ;
        endcase
    end

    assign slot_free  = !out_valid || out_ready;
    assign req0_ready = grant0 && slot_free;
    assign req1_ready = grant1 && slot_free;
    assign accept     = req0_ready || req1_ready;
    assign fire       = out_valid && out_ready;
    assign acc_bin    = req1_ready ? req1_bin : req0_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            gray_q  <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gray_q  <= gray_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
    end

    always_comb begin
        gray_d = gray_q;
        id_d   = id_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        if (accept) begin
            gray_d = acc_bin ^ (acc_bin >> 1);
            id_d   = req1_ready;
            last_d = req1_ready;
        end
        if (fire) cnt_d = cnt_q + 1'b1;
    end

    assign out_gray = gray_q;
    assign out_id   = id_q;
    assign conv_cnt = cnt_q;

endmodule

// File: doc/enc_gray_arb.md
ENC_GRAY_ARB -- requirements
Module: enc_gray_arb

Interface
REQ-001 Parameter WIDTH, default 10, code width in bits for all bin/gray data ports.
REQ-002 Parameter CNTW, default 16, width of the completed-conversion counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid  input  1  requester 0 has a binary word to convert.
REQ-006 req0_bin  input  WIDTH  requester 0 binary word.
REQ-007 req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 has a binary word to convert.
REQ-009 req1_bin  input  WIDTH  requester 1 binary word.
REQ-010 req1_ready  output  1  requester 1 word accepted this cycle.
REQ-011 out_valid  output  1  out_gray/out_id hold a valid result.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 out_gray  output  WIDTH  registered Gray code of the accepted word.
REQ-014 out_id  output  1  index of the requester that produced out_gray.
REQ-015 conv_cnt  output  CNTW  number of results consumed since reset.

Function
REQ-016 Transfer rule: a transfer on any port occurs only in a cycle where that port's valid and ready are both 1 at the rising edge.
REQ-017 Gray rule: out_gray[WIDTH-1] = bin[WIDTH-1], and for i < WIDTH-1, out_gray[i] = bin[i+1] XOR bin[i].
REQ-018 The output stage is a two-state FSM.
- EMPTY: out_valid = 0.
- FULL: out_valid = 1.
REQ-019 The output stage can accept a word ("slot free") when it is in EMPTY, or in FULL with out_ready = 1.
REQ-020 Grant with only one requester valid: that requester is granted.
REQ-021 Grant with both requesters valid: the requester not granted at the last accepted transfer wins (round-robin via register last_id).
REQ-022 Grant with neither requester valid: no grant.
REQ-023 req_i_ready = grant_i AND slot free; at most one ready is 1 per cycle.
REQ-024 ready is combinational from the valids, last_id and out_valid/out_ready; it does not depend on the req_bin values.
REQ-025 On acceptance:
- out_gray and out_id load at the same edge;
- last_id is set to the accepted id;
- the FSM enters FULL.
- Latency is 1 cycle from acceptance to out_valid.
REQ-026 FSM transitions:
- FULL with out_ready = 1 and no acceptance goes to EMPTY.
- FULL with out_ready = 1 and an acceptance in the same cycle stays FULL with the new data, with no bubble.
REQ-027 While FULL and out_ready = 0, out_gray and out_id hold stable and both ready outputs are 0.
REQ-028 A requester that is not granted is not affected: its word stays pending, with no data loss.
REQ-029 conv_cnt increments by 1 on each out_valid AND out_ready cycle and wraps from 2^CNTW-1 to 0.
REQ-030 Requests are not queued internally; the only storage is the single output register.
REQ-031 Throughput is one result per cycle when out_ready is held at 1.

Reset
REQ-032 While rst_n = 0, the block holds the following values immediately, independent of clk:
- FSM = EMPTY;
- out_valid = 0;
- out_gray = 0;
- out_id = 0;
- conv_cnt = 0;
- last_id = 1, so requester 0 wins the first contention.
REQ-033 Reset asserted mid-transfer discards any held result, and no transfer is counted.
REQ-034 The first acceptance is possible at the first rising edge after rst_n deasserts.

Verification
REQ-035 Single request, out_ready = 1.
- Stimulus: req0_bin = 10'h155 with req0_valid.
- Required: req0_ready = 1 that cycle; next cycle out_valid = 1, out_gray = 10'h1FF, out_id = 0; conv_cnt = 1 one cycle after that.
REQ-036 Contention after reset, both valid continuously, out_ready = 1.
- Stimulus: req0_bin = 10'h004, req1_bin = 10'h3FF.
- Required: results alternate 10'h006 (id 0), 10'h200 (id 1), 10'h006 (id 0), one per cycle.
REQ-037 Backpressure.
- Stimulus: hold out_ready = 0 for 3 cycles while FULL.
- Required: out_gray and out_id are constant, both readies are 0, conv_cnt is unchanged.
- Required after out_ready = 1: the pending requester is accepted at that same edge.
REQ-038 Reset mid-operation.
- Stimulus: assert rst_n = 0 asynchronously while FULL.
- Required: out_valid drops to 0 without a clock edge, and conv_cnt = 0.
- Required: the first contention after release grants requester 0.
REQ-039 Counter wrap.
- Stimulus: CNTW = 4, 17 consumed results.
- Required: conv_cnt = 1.
REQ-040 Exhaustive mapping.
- Stimulus: stream all 1024 bin values through requester 1.
- Required: each out_gray matches REQ-017, and consecutive outputs differ in exactly one bit.
